// File: rtl/rtttl_player_ctrl.sv
// RTTTL playback controller: owns tempo timing, pulls note events from the
// sequencer over a valid/ready handshake, holds each note for its duration and
// handles play/pause/stop/loop commands.
//
// Optional articulation gap: define RTTTL_PLAYER_GAP_EN to silence the last
// GAP_TICKS ticks of every note longer than GAP_TICKS.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   cmd_play_i         pulse: start from idle / resume from pause
//   cmd_pause_i        pulse: pause playback
//   cmd_stop_i         pulse: abort to idle (also rewinds the source)
//   loop_en_i          rewind and continue when the end marker is fetched
//   tick_div_i         cycles per 1/64-note tick minus 1 (0 acts as 1)
//   ev_valid_i/ev_ready_o   event handshake; ready only while fetching
//   ev_octave_i, ev_note_i, ev_dur_i   event fields (dur 0 = end of song)
//   src_restart_o      same-cycle pulse telling the source to rewind
//   octave_o, note_o   tone generator drive (note 0 = silent)
//   busy_o             high whenever not idle
//   done_o             one-cycle pulse, coincident with the first idle cycle
//                      after an end marker seen with loop_en_i low
`timescale 1ns/1ps
module rtttl_player_ctrl #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DUR_W     = 7,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_play_i,
  input  logic             cmd_pause_i,
  input  logic             cmd_stop_i,
  input  logic             loop_en_i,
  input  logic [DIV_W-1:0] tick_div_i,
  input  logic             ev_valid_i,
  output logic             ev_ready_o,
  input  logic [3:0]       ev_octave_i,
  input  logic [3:0]       ev_note_i,
  input  logic [DUR_W-1:0] ev_dur_i,
  output logic             src_restart_o,
  output logic [3:0]       octave_o,
  output logic [3:0]       note_o,
  output logic             busy_o,
  output logic             done_o
);

`ifdef RTTTL_PLAYER_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif
  localparam logic [DUR_W-1:0] GapTicks = DUR_W'(GAP_TICKS);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StNote  = 3'd2,
    StGap   = 3'd3,
    StPause = 3'd4
  } state_e;

  state_e             state_q, state_d, saved_q, saved_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d, eff_div;
  logic [DUR_W-1:0]   rem_q, rem_d, rem_dec;
  logic [3:0]         oct_q, oct_d, note_q, note_d;
  logic               gap_ok_q, gap_ok_d, done_q, done_d;

  assign eff_div = (tick_div_i == '0) ? DIV_W'(1) : tick_div_i;
  // Saturating decrement so remaining can never wrap.
  assign rem_dec = (rem_q != '0) ? rem_q - DUR_W'(1) : '0;

  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    div_d         = div_q;
    oct_d         = oct_q;
    note_d        = note_q;
    gap_ok_d      = gap_ok_q;
    done_d        = 1'b0;
    src_restart_o = 1'b0;
    ev_ready_o    = 1'b0;

    if (cmd_stop_i) begin
      state_d       = StIdle;
      cnt_d         = '0;
      rem_d         = '0;
      src_restart_o = 1'b1;
    end else if (cmd_pause_i &&
                 (state_q == StFetch || state_q == StNote || state_q == StGap)) begin
      // Counter and remaining stay frozen while paused.
      saved_d = state_q;
      state_d = StPause;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_play_i) begin
            div_d         = eff_div;
            src_restart_o = 1'b1;
            state_d       = StFetch;
          end
        end
        StPause: begin
          if (cmd_play_i) state_d = saved_q;
        end
        StFetch: begin
          // Only reached without stop/pause, so an accepted event is never lost.
          ev_ready_o = 1'b1;
          if (ev_valid_i) begin
            if (ev_dur_i != '0) begin
              oct_d    = ev_octave_i;
              note_d   = ev_note_i;
              rem_d    = ev_dur_i;
              cnt_d    = '0;
              gap_ok_d = (ev_dur_i > GapTicks);
              state_d  = StNote;
            end else if (loop_en_i) begin
              src_restart_o = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StNote, StGap: begin
          if (cnt_q == div_q) begin
            cnt_d = '0;
            rem_d = rem_dec;
            if (rem_dec == '0) begin
              state_d = StFetch;
            end else if (GapEn && state_q == StNote && gap_ok_q && rem_dec == GapTicks) begin
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      saved_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= DIV_W'(1);
      oct_q    <= '0;
      note_q   <= '0;
      gap_ok_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      oct_q    <= oct_d;
      note_q   <= note_d;
      gap_ok_q <= gap_ok_d;
      done_q   <= done_d;
    end
  end

  // Octave is held through the gap so the tone generator sees only a note-off.
  always_comb begin
    octave_o = (state_q == StNote || state_q == StGap) ? oct_q : 4'd0;
    note_o   = (state_q == StNote) ? note_q : 4'd0;
    busy_o   = (state_q != StIdle);
    done_o   = done_q;
  end

endmodule

// File: tb/tb_rtttl_player_ctrl.sv
`timescale 1ns/1ps
module tb_rtttl_player_ctrl;

`ifdef RTTTL_PLAYER_GAP_EN
  localparam int GapT = 1;
`else
  localparam int GapT = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, cmd_play_i, cmd_pause_i, cmd_stop_i, loop_en_i;
  logic [15:0] tick_div_i;
  logic        ev_valid_i, ev_ready_o;
  logic [3:0]  ev_octave_i, ev_note_i;
  logic [6:0]  ev_dur_i;
  logic        src_restart_o, busy_o, done_o;
  logic [3:0]  octave_o, note_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  rtttl_player_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_play_i   (cmd_play_i),
    .cmd_pause_i  (cmd_pause_i),
    .cmd_stop_i   (cmd_stop_i),
    .loop_en_i    (loop_en_i),
    .tick_div_i   (tick_div_i),
    .ev_valid_i   (ev_valid_i),
    .ev_ready_o   (ev_ready_o),
    .ev_octave_i  (ev_octave_i),
    .ev_note_i    (ev_note_i),
    .ev_dur_i     (ev_dur_i),
    .src_restart_o(src_restart_o),
    .octave_o     (octave_o),
    .note_o       (note_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct {
    int n;
    bit play, pause, stop, loop, valid;
    int dur;
    int e_rdy, e_rs, e_note, e_oct, e_busy, e_done;
  } vec_t;

  vec_t tab[$];

  task automatic add(input int n, input bit play, input bit pause, input bit stop,
                     input bit loop, input bit valid, input int dur, input int e_rdy,
                     input int e_rs, input int e_note, input int e_oct, input int e_busy,
                     input int e_done);
    vec_t v;
    v.n = n; v.play = play; v.pause = pause; v.stop = stop; v.loop = loop;
    v.valid = valid; v.dur = dur; v.e_rdy = e_rdy; v.e_rs = e_rs; v.e_note = e_note;
    v.e_oct = e_oct; v.e_busy = e_busy; v.e_done = e_done;
    tab.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_play_i = 0; cmd_pause_i = 0; cmd_stop_i = 0; ev_valid_i = 0;
  endtask

  // Random song storage
  int s_oct[8], s_note[8], s_dur[8];
  int s_len;

  task automatic run_song(input int seed_idx);
    int raw, e, ptr, k, nlen, slen, budget, cur;
    bit in_note, fin, clr_loop;
    s_len = $urandom_range(2, 5) + 1;
    for (int i = 0; i < s_len; i++) begin
      s_oct[i]  = $urandom_range(0, 15);
      s_note[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      s_dur[i]  = (i == s_len - 1) ? 0 : $urandom_range(1, 6);
    end
    raw = $urandom_range(0, 4);
    e   = (raw == 0) ? 1 : raw;
    loop_en_i  = 1;
    idle_inputs();
    tick_div_i = 16'(raw);
    cmd_play_i = 1;
    #1;
    chk($sformatf("song%0d play_restart", seed_idx), int'(src_restart_o), 1);
    step();
    cmd_play_i = 0;
    ptr = 0; k = 0; in_note = 0; fin = 0; budget = 0; cur = 0; nlen = 0; slen = 0;
    while (!fin) begin
      clr_loop   = 0;
      // Later tick_div changes must not affect this song.
      tick_div_i = 16'($urandom_range(0, 9));
      ev_valid_i = (ptr < s_len) && ($urandom_range(0, 3) != 0);
      if (ptr < s_len) begin
        ev_octave_i = 4'(s_oct[ptr]); ev_note_i = 4'(s_note[ptr]); ev_dur_i = 7'(s_dur[ptr]);
      end
      #1;
      chk("rnd busy", int'(busy_o), 1);
      chk("rnd done", int'(done_o), 0);
      if (in_note) begin
        chk("rnd ready_in_note", int'(ev_ready_o), 0);
        chk("rnd note", int'(note_o), (k < slen) ? s_note[cur] : 0);
        chk("rnd octave", int'(octave_o), s_oct[cur]);
        chk("rnd restart", int'(src_restart_o), 0);
        k++;
        if (k == nlen) in_note = 0;
      end else begin
        chk("rnd ready_fetch", int'(ev_ready_o), 1);
        chk("rnd fetch_note", int'(note_o), 0);
        chk("rnd fetch_oct", int'(octave_o), 0);
        if (ev_valid_i && s_dur[ptr] != 0) begin
          chk("rnd restart", int'(src_restart_o), 0);
          cur = ptr; ptr++; k = 0; in_note = 1;
          nlen = s_dur[cur] * (e + 1);
          slen = ((s_dur[cur] > GapT) ? s_dur[cur] - GapT : s_dur[cur]) * (e + 1);
        end else if (ev_valid_i && loop_en_i) begin
          chk("rnd loop_restart", int'(src_restart_o), 1);
          ptr = 0; clr_loop = 1;
        end else begin
          chk("rnd restart", int'(src_restart_o), 0);
          if (ev_valid_i) fin = 1;
        end
      end
      step();
      if (clr_loop) loop_en_i = 0;
      budget++;
      if (budget > 4000) begin
        chk("rnd timeout", 1, 0);
        fin = 1;
      end
    end
    ev_valid_i = 0;
    #1;
    chk("rnd end_done", int'(done_o), 1);
    chk("rnd end_busy", int'(busy_o), 0);
    step();
    chk("rnd done_once", int'(done_o), 0);
  endtask

  initial begin
    rst_i = 1; loop_en_i = 0; tick_div_i = 16'd3;
    ev_octave_i = 4'd5; ev_note_i = 4'd6; ev_dur_i = 7'd0;
    idle_inputs();

    // n, play,pause,stop,loop,valid,dur, rdy,rs,note,oct,busy,done
    add(1, 0,0,0,0,0,0, 0,0,0,0,0,0);
    add(1, 1,0,0,0,0,0, 0,1,0,0,0,0);
    add(1, 0,0,0,0,1,4, 1,0,0,0,1,0);
`ifdef RTTTL_PLAYER_GAP_EN
    add(12, 0,0,0,0,0,0, 0,0,6,5,1,0);
    add(4,  0,0,0,0,0,0, 0,0,0,5,1,0);
`else
    add(16, 0,0,0,0,0,0, 0,0,6,5,1,0);
`endif
    add(3, 0,0,0,0,0,0, 1,0,0,0,1,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,1,0);
    add(1, 0,0,0,0,0,0, 0,0,0,0,0,1);
    add(1, 0,0,0,0,0,0, 0,0,0,0,0,0);
    // stop + pause together during NOTE; replay starts from FETCH
    add(1, 1,0,0,0,0,0, 0,1,0,0,0,0);
    add(1, 0,0,0,0,1,4, 1,0,0,0,1,0);
    add(5, 0,0,0,0,0,0, 0,0,6,5,1,0);
    add(1, 0,1,1,0,0,0, 0,1,6,5,1,0);
    add(1, 0,0,0,0,0,0, 0,0,0,0,0,0);
    add(1, 1,0,0,0,0,0, 0,1,0,0,0,0);
    add(1, 0,0,0,0,0,0, 1,0,0,0,1,0);
    // pause 5 cycles into a note, hold, resume
    add(1, 0,0,0,0,1,4, 1,0,0,0,1,0);
    add(5, 0,0,0,0,0,0, 0,0,6,5,1,0);
    add(1, 0,1,0,0,0,0, 0,0,6,5,1,0);
    add(20, 0,0,0,0,0,0, 0,0,0,0,1,0);
    add(1, 1,0,0,0,0,0, 0,0,0,0,1,0);
`ifdef RTTTL_PLAYER_GAP_EN
    add(7, 0,0,0,0,0,0, 0,0,6,5,1,0);
    add(4, 0,0,0,0,0,0, 0,0,0,5,1,0);
`else
    add(11, 0,0,0,0,0,0, 0,0,6,5,1,0);
`endif
    add(1, 0,0,0,0,0,0, 1,0,0,0,1,0);
    add(1, 0,0,1,0,0,0, 0,1,0,0,1,0);
    add(1, 0,0,0,0,0,0, 0,0,0,0,0,0);
    // end marker with loop, then without
    add(1, 1,0,0,0,0,0, 0,1,0,0,0,0);
    add(1, 0,0,0,1,1,0, 1,1,0,0,1,0);
    add(1, 0,0,0,1,0,0, 1,0,0,0,1,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,1,0);
    add(1, 0,0,0,0,0,0, 0,0,0,0,0,1);
    // stop and pause in IDLE
    add(1, 0,0,1,0,0,0, 0,1,0,0,0,0);
    add(1, 0,1,0,0,0,0, 0,0,0,0,0,0);
    add(1, 1,0,0,0,0,0, 0,1,0,0,0,0);
    add(1, 0,0,0,0,0,0, 1,0,0,0,1,0);
    add(1, 0,0,1,0,0,0, 0,1,0,0,1,0);
    add(1, 0,0,0,0,0,0, 0,0,0,0,0,0);

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;

    for (int r = 0; r < tab.size(); r++) begin
      for (int i = 0; i < tab[r].n; i++) begin
        cmd_play_i = tab[r].play; cmd_pause_i = tab[r].pause; cmd_stop_i = tab[r].stop;
        loop_en_i = tab[r].loop; ev_valid_i = tab[r].valid; ev_dur_i = 7'(tab[r].dur);
        #1;
        chk($sformatf("row%0d.%0d ready", r, i), int'(ev_ready_o), tab[r].e_rdy);
        chk($sformatf("row%0d.%0d restart", r, i), int'(src_restart_o), tab[r].e_rs);
        chk($sformatf("row%0d.%0d note", r, i), int'(note_o), tab[r].e_note);
        chk($sformatf("row%0d.%0d octave", r, i), int'(octave_o), tab[r].e_oct);
        chk($sformatf("row%0d.%0d busy", r, i), int'(busy_o), tab[r].e_busy);
        chk($sformatf("row%0d.%0d done", r, i), int'(done_o), tab[r].e_done);
        step();
      end
    end
    idle_inputs();
    loop_en_i = 0;

    // Reset in the middle of a note
    cmd_play_i = 1;
    step();
    cmd_play_i = 0; ev_valid_i = 1; ev_octave_i = 4'd5; ev_note_i = 4'd6; ev_dur_i = 7'd4;
    step();
    ev_valid_i = 0;
    repeat (3) step();
    chk("midnote note", int'(note_o), 6);
    chk("midnote octave", int'(octave_o), 5);
    rst_i = 1;
    step();
    rst_i = 0;
    #1;
    chk("reset note", int'(note_o), 0);
    chk("reset octave", int'(octave_o), 0);
    chk("reset busy", int'(busy_o), 0);
    chk("reset ready", int'(ev_ready_o), 0);
    chk("reset done", int'(done_o), 0);
    chk("reset restart", int'(src_restart_o), 0);
    step();

    for (int s = 0; s < 25; s++) run_song(s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtttl_player_ctrl.md
Name: rtttl_player_ctrl

Overview:
- Playback controller between a note-event source (ROM-style RTTTL sequencer) and the tone generator.
- Owns tempo timing: generates the 1/64-note tick from a programmable divisor.
- Pulls note events over a valid/ready handshake and holds each note on octave/note for its duration.
- Handles play/pause/stop/loop commands and drives the source rewind pulse.

Parameters:
- DIV_W, 16, width of tick divisor and tick counter.
- DUR_W, 7, width of event duration field, in 1/64-note ticks.
- GAP_TICKS, 1, silent articulation ticks at end of each note; used only with RTTTL_PLAYER_GAP_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_play  in  1  single-cycle pulse: start from IDLE, or resume from PAUSE
- cmd_pause  in  1  single-cycle pulse: pause playback
- cmd_stop  in  1  single-cycle pulse: abort to IDLE
- loop_en  in  1  on end marker, rewind the source and continue
- tick_div  in  DIV_W  clock cycles per tick minus 1; 0 is treated as 1
- ev_valid  in  1  source event valid
- ev_ready  out  1  controller accepts an event
- ev_octave  in  4  event octave
- ev_note  in  4  event note; 0 is a rest
- ev_dur  in  DUR_W  event length in ticks; 0 is the end-of-song marker
- src_restart  out  1  one-cycle pulse telling the source to rewind to address 0
- octave  out  4  to tone generator
- note  out  4  to tone generator; 0 means silent
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of song when loop_en=0

Behaviour:
- Reset: state=IDLE; octave=0, note=0, ev_ready=0, src_restart=0, busy=0, done=0; tick counter=0, remaining=0, divisor latch=1.
- States: IDLE(0), FETCH(1), NOTE(2), GAP(3), PAUSE(4). ev_ready=1 only in FETCH.
- Command priority within one cycle: stop > pause > play.
- Command effects by state:
  - stop, any state: go to IDLE next cycle, outputs 0, tick counter cleared, src_restart pulses the same cycle. Stop in IDLE only pulses src_restart.
  - play in IDLE: latch eff_div = max(tick_div,1), pulse src_restart, go to FETCH.
  - play in PAUSE: return to the saved state.
  - play in FETCH/NOTE/GAP: ignored.
  - pause in FETCH/NOTE/GAP: save state, go to PAUSE. Outputs forced to 0; tick counter and remaining are frozen.
  - pause in IDLE/PAUSE: ignored.
  - Resume into NOTE restores the latched octave/note the next cycle.
- FETCH, handshake at ev_valid && ev_ready:
  - ev_dur != 0: next cycle octave/note take the event values, remaining=ev_dur, tick counter=0, state=NOTE.
  - ev_dur == 0 with loop_en=1: pulse src_restart, stay in FETCH.
  - ev_dur == 0 with loop_en=0: go to IDLE, pulse done, outputs 0.
  - While ev_valid=0, outputs are held at 0 (silence).
- Tick: counter runs only in NOTE and GAP. tick asserts when counter==eff_div, then counter wraps to 0. So a tick period is eff_div+1 cycles.
- On each tick, remaining decrements. When remaining reaches 0, the next state is FETCH. Total NOTE+GAP time = ev_dur*(eff_div+1) cycles; FETCH adds at least 1 cycle per event.
- tick_div changes only take effect on the next play from IDLE.
- Width rules: remaining is DUR_W bits and never underflows. Tick counter is DIV_W bits with compare-equality wrap.

Optional Feature:
- Macro: RTTTL_PLAYER_GAP_EN.
- Defined: in NOTE, when a tick leaves remaining==GAP_TICKS and ev_dur > GAP_TICKS, go to GAP. In GAP, note=0 and octave is held; go to FETCH when remaining reaches 0. Events with ev_dur <= GAP_TICKS play the full duration with no gap.
- Undefined: GAP state is unreachable; each note sounds for its full duration; GAP_TICKS is ignored.

Test Plan:
- Reset mid-NOTE (octave=5, note=6) -> the cycle after rst, octave=0, note=0, busy=0, state IDLE, ev_ready=0.
- tick_div=3, play, event (5,6,dur=4), no gap -> src_restart pulse at play; note=6 for exactly 16 cycles; ev_ready high in the following cycle.
- Same stimulus with RTTTL_PLAYER_GAP_EN, GAP_TICKS=1 -> note=6 for 12 cycles, then note=0 for 4 cycles, then FETCH.
- Pause 5 cycles into a dur=4, tick_div=3 note; hold 20 cycles; play -> silence during pause, note=6 restored, remaining sounding time is exactly 11 cycles.
- End marker with loop_en=1, then loop_en=0 -> first: src_restart pulse, state stays FETCH; second: done pulse, state IDLE, busy=0.
- cmd_stop and cmd_pause in the same cycle during NOTE -> IDLE, src_restart=1; the following cmd_play restarts from FETCH, not the paused note.
